// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types and constants for the configurable UART transmitter.
//   par_mode_t  : parity selection presented on PAR_MODEi (2'b11 reserved, means none)
//   tx_state_t  : transmitter frame states
//   MIN_CLK_PER_BIT : smallest bit period the divisor is clamped to
//   Parity support is built only when UART_TX_PARITY_EN is defined; the helpers
//   below are harmless when it is not.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } par_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int MIN_CLK_PER_BIT = 2;

  // Reserved encoding 2'b11 falls through to "no parity bit".
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  function automatic logic par_bit(input logic [1:0] mode, input logic data_xor);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
//   Bit-period timer for the UART transmitter. The divisor is captured on load,
//   clamped to MIN_CLK_PER_BIT, and held for the whole frame.
//   Ports:
//     CLKip   in  1         system clock
//     RSTNi   in  1         asynchronous active-low reset
//     load    in  1         capture div and restart the count at 0
//     run     in  1         count while a frame is in progress
//     div     in  DIV_WDTH  requested clocks per bit
//     bit_end out 1         high on the last clock of every bit
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_WDTH = 16
) (
  input  logic                CLKip,
  input  logic                RSTNi,
  input  logic                load,
  input  logic                run,
  input  logic [DIV_WDTH-1:0] div,
  output logic                bit_end
);

  localparam logic [DIV_WDTH-1:0] DIV_MIN = DIV_WDTH'(MIN_CLK_PER_BIT);

  logic [DIV_WDTH-1:0] div_q;
  logic [DIV_WDTH-1:0] cnt_q;
  logic [DIV_WDTH-1:0] div_clamped;

  assign div_clamped = (div < DIV_MIN) ? DIV_MIN : div;
  assign bit_end     = run && (cnt_q == (div_q - DIV_WDTH'(1)));

  always_ff @(posedge CLKip or negedge RSTNi) begin
    if (!RSTNi) begin
      div_q <= DIV_MIN;
      cnt_q <= '0;
    end else if (load) begin
      div_q <= div_clamped;
      cnt_q <= '0;
    end else if (run) begin
      if (bit_end) cnt_q <= '0;
      else         cnt_q <= cnt_q + DIV_WDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg
//   Configurable UART transmitter: start + DATA_WDTH data bits (LSB first)
//   + optional parity + 1 or 2 stop bits. Words arrive on a valid/ready handshake;
//   data and frame configuration are latched on accept.
//   Optional build macro: UART_TX_PARITY_EN (parity bit and PARITY state built).
//   Ports:
//     CLKip        in  1          system clock
//     RSTNi        in  1          asynchronous active-low reset
//     TX_DATAi     in  DATA_WDTH  word to send
//     TX_VALIDi    in  1          word available
//     TX_READYo    out 1          ready to accept (IDLE only)
//     CLK_PER_BITi in  DIV_WDTH   clocks per bit (0 and 1 act as 2)
//     STOP2i       in  1          two stop bits when 1
//     PAR_MODEi    in  2          parity mode (par_mode_t)
//     BUSYo        out 1          frame in progress
//     DONEo        out 1          one-cycle pulse after the last stop bit
//     DATAo        out 1          serial line, idle high
//
//   state  | meaning
//   IDLE   | line high, ready for a word
//   START  | start bit (line low)
//   DATA   | data bits, LSB first
//   PARITY | parity bit (only with UART_TX_PARITY_EN)
//   STOP   | one or two stop bits (line high)
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_WDTH = 8,
  parameter int DIV_WDTH  = 16
) (
  input  logic                 CLKip,
  input  logic                 RSTNi,
  input  logic [DATA_WDTH-1:0] TX_DATAi,
  input  logic                 TX_VALIDi,
  output logic                 TX_READYo,
  input  logic [DIV_WDTH-1:0]  CLK_PER_BITi,
  input  logic                 STOP2i,
  input  logic [1:0]           PAR_MODEi,
  output logic                 BUSYo,
  output logic                 DONEo,
  output logic                 DATAo
);

  localparam int IDX_WDTH = (DATA_WDTH > 1) ? $clog2(DATA_WDTH) : 1;
  localparam logic [IDX_WDTH-1:0] IDX_LAST = IDX_WDTH'(DATA_WDTH - 1);

  tx_state_t            state_q, state_nxt;
  logic [DATA_WDTH-1:0] data_q;
  logic [IDX_WDTH-1:0]  bit_idx_q, idx_nxt;
  logic                 stop2_q;
  logic                 stop_cnt_q;
  logic                 accept;
  logic                 bit_end;
  logic                 last_data;

  logic ready_q, busy_q, done_q, line_q;
  logic ready_d, busy_d, done_d, line_d;

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_q;
`else
  logic unused_par_mode;
  assign unused_par_mode = ^PAR_MODEi;
`endif

  // ready_q is only ever high while in IDLE, so it doubles as the accept gate.
  assign accept    = TX_VALIDi && ready_q;
  assign last_data = (bit_idx_q == IDX_LAST);
  assign idx_nxt   = (state_q == DATA && bit_end) ? bit_idx_q + IDX_WDTH'(1) : bit_idx_q;

  uart_baud_gen #(
    .DIV_WDTH(DIV_WDTH)
  ) u_baud (
    .CLKip  (CLKip),
    .RSTNi  (RSTNi),
    .load   (accept),
    .run    (state_q != IDLE),
    .div    (CLK_PER_BITi),
    .bit_end(bit_end)
  );

  always_ff @(posedge CLKip or negedge RSTNi) begin
    if (!RSTNi) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:  if (accept) state_nxt = START;
      START: if (bit_end) state_nxt = DATA;
      DATA: begin
        if (bit_end && last_data) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = par_en_q ? PARITY : STOP;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_nxt = STOP;
`endif
      STOP:  if (bit_end && (stop_cnt_q == stop2_q)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output values are decoded from the next state and registered, so every
  // output changes on the same edge as the state it reflects.
  always_comb begin
    line_d  = 1'b1;
    busy_d  = (state_nxt != IDLE);
    ready_d = (state_nxt == IDLE);
    done_d  = (state_q == STOP) && (state_nxt == IDLE);
    case (state_nxt)
      START:  line_d = 1'b0;
      DATA:   line_d = data_q[idx_nxt];
`ifdef UART_TX_PARITY_EN
      PARITY: line_d = par_q;
`endif
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLKip or negedge RSTNi) begin
    if (!RSTNi) begin
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      line_q  <= line_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge CLKip or negedge RSTNi) begin
    if (!RSTNi) begin
      data_q     <= '0;
      bit_idx_q  <= '0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
    end else begin
      if (accept) begin
        data_q     <= TX_DATAi;
        stop2_q    <= STOP2i;
        bit_idx_q  <= '0;
        stop_cnt_q <= 1'b0;
      end else begin
        bit_idx_q <= idx_nxt;
        if (state_q == STOP && bit_end) stop_cnt_q <= 1'b1;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge CLKip or negedge RSTNi) begin
    if (!RSTNi) begin
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
    end else if (accept) begin
      par_en_q <= par_enabled(PAR_MODEi);
      par_q    <= par_bit(PAR_MODEi, ^TX_DATAi);
    end
  end
`endif

  assign TX_READYo = ready_q;
  assign BUSYo     = busy_q;
  assign DONEo     = done_q;
  assign DATAo     = line_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
module tb_uart_tx_cfg;

  logic        CLKip = 1'b0;
  logic        RSTNi = 1'b0;
  logic [7:0]  TX_DATAi = '0;
  logic        TX_VALIDi = 1'b0;
  logic        TX_READYo;
  logic [15:0] CLK_PER_BITi = '0;
  logic        STOP2i = 1'b0;
  logic [1:0]  PAR_MODEi = '0;
  logic        BUSYo;
  logic        DONEo;
  logic        DATAo;

  int total = 0;
  int bad   = 0;

  always #5 CLKip = ~CLKip;

  uart_tx_cfg #(.DATA_WDTH(8), .DIV_WDTH(16)) dut (
    .CLKip       (CLKip),
    .RSTNi       (RSTNi),
    .TX_DATAi    (TX_DATAi),
    .TX_VALIDi   (TX_VALIDi),
    .TX_READYo   (TX_READYo),
    .CLK_PER_BITi(CLK_PER_BITi),
    .STOP2i      (STOP2i),
    .PAR_MODEi   (PAR_MODEi),
    .BUSYo       (BUSYo),
    .DONEo       (DONEo),
    .DATAo       (DATAo)
  );

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic        stop2;
    logic [1:0]  par;
    logic [11:0] bits;    // expected line, first bit in bit 0
    int          nbits;
    int          bitlen;
    string       name;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!TX_READYo && n < 200) begin
      @(negedge CLKip);
      n++;
    end
    if (!TX_READYo) check({name, "_ready_timeout"}, {31'd0, TX_READYo}, 32'd1);
  endtask

  // Presents one word, scrambles all inputs right after accept, then checks
  // the line cycle by cycle and the end-of-frame flags.
  task automatic send_frame(input vec_t v);
    int line_err, flag_err, tot;
    @(negedge CLKip);
    TX_DATAi = v.data; CLK_PER_BITi = v.div; STOP2i = v.stop2; PAR_MODEi = v.par;
    TX_VALIDi = 1'b1;
    wait_ready(v.name);
    @(negedge CLKip);
    TX_VALIDi = 1'b0; TX_DATAi = ~v.data; CLK_PER_BITi = 16'd9;
    STOP2i = ~v.stop2; PAR_MODEi = 2'b01;
    tot = v.nbits * v.bitlen;
    line_err = 0; flag_err = 0;
    for (int c = 1; c <= tot; c++) begin
      if (c > 1) @(negedge CLKip);
      if (DATAo !== v.bits[(c-1)/v.bitlen]) line_err++;
      if (BUSYo !== 1'b1 || TX_READYo !== 1'b0 || DONEo !== 1'b0) flag_err++;
    end
    check({v.name, "_line"}, line_err, 0);
    check({v.name, "_flags"}, flag_err, 0);
    @(negedge CLKip);
    check({v.name, "_done"}, {28'd0, DONEo, BUSYo, TX_READYo, DATAo}, 32'hB);
    @(negedge CLKip);
    check({v.name, "_idle"}, {28'd0, DONEo, BUSYo, TX_READYo, DATAo}, 32'h3);
  endtask

  initial begin
    logic [7:0] w[3];
    logic       line_log[0:199];
    int         acc_cyc[3];
    int         done_cyc[3];
    int         nacc, ndone, overlap_err, idle_err, pending;
    logic [7:0] dec;

    vecs[0] = '{8'hA5, 16'd4, 1'b0, 2'b00, 12'({1'b1, 8'hA5, 1'b0}), 10, 4, "8n1_a5"};
`ifdef UART_TX_PARITY_EN
    vecs[1] = '{8'h07, 16'd3, 1'b1, 2'b01, 12'({2'b11, 1'b1, 8'h07, 1'b0}), 12, 3, "8e2_07"};
    vecs[2] = '{8'h07, 16'd3, 1'b0, 2'b10, 12'({1'b1, 1'b0, 8'h07, 1'b0}), 11, 3, "8o1_07"};
    vecs[6] = '{8'hFF, 16'd5, 1'b0, 2'b01, 12'({1'b1, 1'b0, 8'hFF, 1'b0}), 11, 5, "8e1_ff"};
`else
    vecs[1] = '{8'h07, 16'd3, 1'b1, 2'b01, 12'({2'b11, 8'h07, 1'b0}), 11, 3, "8e2_07"};
    vecs[2] = '{8'h07, 16'd3, 1'b0, 2'b10, 12'({1'b1, 8'h07, 1'b0}), 10, 3, "8o1_07"};
    vecs[6] = '{8'hFF, 16'd5, 1'b0, 2'b01, 12'({1'b1, 8'hFF, 1'b0}), 10, 5, "8e1_ff"};
`endif
    vecs[3] = '{8'h3C, 16'd0, 1'b0, 2'b00, 12'({1'b1, 8'h3C, 1'b0}), 10, 2, "div0_3c"};
    vecs[4] = '{8'hC3, 16'd1, 1'b1, 2'b00, 12'({2'b11, 8'hC3, 1'b0}), 11, 2, "div1_c3"};
    vecs[5] = '{8'h5A, 16'd2, 1'b0, 2'b11, 12'({1'b1, 8'h5A, 1'b0}), 10, 2, "resv_5a"};

    // Reset values and ready timing.
    #12;
    check("reset_outputs", {28'd0, DONEo, BUSYo, TX_READYo, DATAo}, 32'h1);
    @(negedge CLKip);
    RSTNi = 1'b1;
    #1;
    check("ready_at_release", {31'd0, TX_READYo}, 32'd0);
    @(negedge CLKip);
    check("ready_after_release", {31'd0, TX_READYo}, 32'd1);

    // Idle with no valid: line stays high, no DONE.
    idle_err = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLKip);
      if (DATAo !== 1'b1 || DONEo !== 1'b0 || BUSYo !== 1'b0) idle_err++;
    end
    check("idle_quiet", idle_err, 0);

    for (int i = 0; i < 7; i++) send_frame(vecs[i]);

    // Back-to-back frames with valid held high, DIV=2, 8N1.
    w[0] = 8'h81; w[1] = 8'h42; w[2] = 8'h3C;
    nacc = 0; ndone = 0; overlap_err = 0; pending = 0;
    @(negedge CLKip);
    TX_DATAi = w[0]; CLK_PER_BITi = 16'd2; STOP2i = 1'b0; PAR_MODEi = 2'b00;
    TX_VALIDi = 1'b1;
    for (int c = 0; c < 120; c++) begin
      line_log[c] = DATAo;
      if (DONEo && ndone < 3) begin done_cyc[ndone] = c; ndone++; end
      else if (DONEo) ndone++;
      if (TX_READYo && BUSYo) overlap_err++;
      pending = 0;
      if (TX_READYo && TX_VALIDi && nacc < 3) begin
        acc_cyc[nacc] = c; nacc++; pending = 1;
      end
      @(posedge CLKip);
      #1;
      if (pending != 0) begin
        if (nacc < 3) TX_DATAi = w[nacc];
        else TX_VALIDi = 1'b0;
      end
      @(negedge CLKip);
    end
    check("b2b_accepts", nacc, 3);
    check("b2b_dones", ndone, 3);
    check("b2b_ready_busy_overlap", overlap_err, 0);
    if (nacc == 3 && ndone == 3) begin
      check("b2b_gap01", acc_cyc[1] - acc_cyc[0], 21);
      check("b2b_gap12", acc_cyc[2] - acc_cyc[1], 21);
      for (int j = 0; j < 3; j++) begin
        check($sformatf("b2b_done_pos%0d", j), done_cyc[j] - acc_cyc[j], 21);
        check($sformatf("b2b_start%0d", j), {31'd0, line_log[acc_cyc[j] + 2]}, 32'd0);
        for (int i = 0; i < 8; i++) dec[i] = line_log[acc_cyc[j] + 2 + 2 * (1 + i)];
        check($sformatf("b2b_word%0d", j), {24'd0, dec}, {24'd0, w[j]});
        check($sformatf("b2b_gap_line%0d", j), {31'd0, line_log[acc_cyc[j] + 21]}, 32'd1);
      end
    end

    // Reset during data bit 3 of 8'h00, DIV=4.
    @(negedge CLKip);
    TX_DATAi = 8'h00; CLK_PER_BITi = 16'd4; STOP2i = 1'b0; PAR_MODEi = 2'b00;
    TX_VALIDi = 1'b1;
    wait_ready("rst_frame");
    @(negedge CLKip);
    TX_VALIDi = 1'b0;
    repeat (17) @(negedge CLKip);
    check("pre_rst_bit3", {30'd0, BUSYo, DATAo}, 32'h2);
    #1;
    RSTNi = 1'b0;
    #1;
    check("rst_async", {28'd0, DONEo, BUSYo, TX_READYo, DATAo}, 32'h1);
    idle_err = 0;
    repeat (3) begin
      @(negedge CLKip);
      if (DONEo !== 1'b0 || DATAo !== 1'b1) idle_err++;
    end
    RSTNi = 1'b1;
    repeat (4) begin
      @(negedge CLKip);
      if (DONEo !== 1'b0 || DATAo !== 1'b1 || BUSYo !== 1'b0) idle_err++;
    end
    check("rst_no_done", idle_err, 0);
    send_frame(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
